// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C bus arbiter: FSM encoding,
// direction codes and the command/response payloads.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_STOP  = 3'd4,
        ST_RESP  = 3'd5
    } state_e;

    localparam logic WR_WRITE = 1'b0;
    localparam logic WR_READ  = 1'b1;

    localparam logic [7:0] DEF_DEV_ADDR = 8'b1001_1101;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } cmd_t;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } rsp_t;

    // Response byte: only a successful read returns data.
    function automatic logic [7:0] rsp_byte(input logic wr, input logic nack,
                                            input logic [7:0] rdata);
        return (wr == WR_READ && !nack) ? rdata : 8'h00;
    endfunction

endpackage

// File: rtl/i2c_rr_pick.sv
// Round-robin picker: first set request at or after ptr_i, wrapping
// modulo NREQ. Purely combinational.
module i2c_rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IW'((32'(ptr_i) + i) % NREQ);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one I2C master between NREQ clients: round-robin grant, command
// latch, start/stop sequencing, watchdog and one-hot response return.
module i2c_bus_arbiter
    import i2c_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_wr,
    input  logic [8*NREQ-1:0] req_addr,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [7:0]        rsp_data,
    output logic              rsp_err,
    output logic              mst_start,
    output logic              mst_stop,
    output logic              mst_wr,
    output logic [7:0]        mst_addr,
    output logic [7:0]        mst_data,
    input  logic [7:0]        mst_rdata,
    input  logic              mst_done,
    input  logic              mst_nack,
    output logic              busy
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e          state_q,     state_d;
    logic [IW-1:0]   ptr_q,       ptr_d;
    logic [IW-1:0]   win_q,       win_d;
    logic [NREQ-1:0] gnt_q,       gnt_d;
    cmd_t            cmd_q,       cmd_d;
    rsp_t            rsp_q,       rsp_d;
    logic [TW-1:0]   wd_q,        wd_d;
    logic            start_q,     start_d;
    logic            stop_q,      stop_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic            busy_q,      busy_d;

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [TW-1:0]   wd_inc;

    logic [7:0] addr_arr [NREQ];
    logic [7:0] data_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr[g] = req_addr[8*g +: 8];
        assign data_arr[g] = req_data[8*g +: 8];
    end

    i2c_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign wd_inc = wd_q + TW'(1);

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        gnt_d       = gnt_q;
        cmd_d       = cmd_q;
        rsp_d       = rsp_q;
        wd_d        = wd_q;
        start_d     = 1'b0;
        stop_d      = 1'b0;
        rsp_valid_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    win_d   = pick_idx;
                    gnt_d   = pick_gnt;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                cmd_d   = '{wr: req_wr[win_q], addr: addr_arr[win_q], data: data_arr[win_q]};
                start_d = 1'b1;
                state_d = ST_START;
            end
            ST_START: begin
                wd_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                wd_d = wd_inc;
                // A done on the timeout edge still counts as a completion.
                if (mst_done) begin
                    rsp_d   = '{err: mst_nack, data: rsp_byte(cmd_q.wr, mst_nack, mst_rdata)};
                    stop_d  = 1'b1;
                    state_d = ST_STOP;
                end else if (wd_inc == TW'(TIMEOUT)) begin
                    rsp_d   = '{err: 1'b1, data: 8'h00};
                    stop_d  = 1'b1;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                rsp_valid_d = gnt_q;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                gnt_d   = '0;
                ptr_d   = (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            gnt_q       <= '0;
            cmd_q       <= '{wr: WR_READ, addr: 8'h00, data: 8'h00};
            rsp_q       <= '{err: 1'b0, data: 8'h00};
            wd_q        <= '0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            gnt_q       <= gnt_d;
            cmd_q       <= cmd_d;
            rsp_q       <= rsp_d;
            wd_q        <= wd_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_q.data;
    assign rsp_err   = rsp_q.err;
    assign mst_start = start_q;
    assign mst_stop  = stop_q;
    assign mst_wr    = cmd_q.wr;
    assign mst_addr  = cmd_q.addr;
    assign mst_data  = cmd_q.data;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter: directed vector table, random
// transactions against a behavioural arbitration model, and reset abort.
module tb_i2c_bus_arbiter;
    import i2c_pkg::*;

    localparam int NREQ = 4;
    localparam int TMO  = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req, req_wr;
    logic [8*NREQ-1:0] req_addr, req_data;
    logic [NREQ-1:0]   gnt, rsp_valid;
    logic [7:0]        rsp_data;
    logic              rsp_err, mst_start, mst_stop, mst_wr;
    logic [7:0]        mst_addr, mst_data, mst_rdata;
    logic              mst_done, mst_nack, busy;

    int n_vec = 0;
    int n_err = 0;
    int ptr_m = 0;

    always #5 clk = ~clk;

    i2c_bus_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO), .TW(16)) dut (
        .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
        .req_data(req_data), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .mst_start(mst_start), .mst_stop(mst_stop), .mst_wr(mst_wr),
        .mst_addr(mst_addr), .mst_data(mst_data), .mst_rdata(mst_rdata),
        .mst_done(mst_done), .mst_nack(mst_nack), .busy(busy)
    );

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          d;      // done in the d-th cycle after mst_start; 0 = never
        logic        nack;
        logic [7:0]  rdata;
        bit          drop;
        logic [3:0]  exp_gnt;
        logic        exp_err;
        logic [7:0]  exp_data;
        int          exp_lat;
    } vec_t;

    vec_t tbl [17];

    // observations from one transaction
    logic [3:0] o_gnt, o_rv;
    logic [7:0] o_rd, o_saddr, o_sdata;
    logic       o_re, o_swr, o_stop_err;
    int         o_gnt_bad, o_starts, o_start_cyc, o_stops, o_stop_cyc, o_lat;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int model_pick(input logic [3:0] r, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic run_txn(input logic [3:0] r, input logic [3:0] wr, input logic [31:0] ad,
                           input logic [31:0] dt, input int d, input logic nk,
                           input logic [7:0] rd, input bit drop);
        int s;
        @(negedge clk);
        chk("idle_before_req", {28'h0, busy, 3'b0} | {28'h0, gnt}, 32'h0);
        req = r; req_wr = wr; req_addr = ad; req_data = dt;
        mst_nack = nk; mst_rdata = rd; mst_done = 1'b0;
        o_gnt = '0; o_gnt_bad = 0; o_starts = 0; o_start_cyc = -1; o_stops = 0;
        o_stop_cyc = -1; o_stop_err = 1'b0; o_rv = '0; o_rd = '0; o_re = 1'b0; o_lat = -1;
        o_saddr = '0; o_sdata = '0; o_swr = 1'b0; s = -1;
        for (int cyc = 1; cyc <= 200 && o_lat < 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) o_gnt = gnt;
            else if (gnt !== o_gnt) o_gnt_bad++;
            if ($countones(gnt) != 1) o_gnt_bad++;
            if (mst_start) begin
                o_starts++; o_start_cyc = cyc; s = cyc;
                o_saddr = mst_addr; o_sdata = mst_data; o_swr = mst_wr;
            end
            if (mst_stop) begin o_stops++; o_stop_cyc = cyc; o_stop_err = rsp_err; end
            if (rsp_valid != '0) begin o_rv = rsp_valid; o_rd = rsp_data; o_re = rsp_err; o_lat = cyc; end
            if (drop && cyc == 1) req = '0;
            mst_done = (d > 0 && s > 0 && cyc == s + d);
        end
        mst_done = 1'b0;
    endtask

    task automatic check_txn(input string tag, input logic [3:0] wr, input logic [31:0] ad,
                             input logic [31:0] dt, input logic [3:0] eg, input logic ee,
                             input logic [7:0] ed, input int el);
        int w = 0;
        for (int i = 0; i < NREQ; i++) if (eg[i]) w = i;
        chk({tag, ".gnt"},        32'(o_gnt), 32'(eg));
        chk({tag, ".gnt_stable"}, 32'(o_gnt_bad), 32'd0);
        chk({tag, ".starts"},     32'(o_starts), 32'd1);
        chk({tag, ".start_cyc"},  32'(o_start_cyc), 32'd2);
        chk({tag, ".mst_addr"},   32'(o_saddr), 32'(ad[8*w +: 8]));
        chk({tag, ".mst_data"},   32'(o_sdata), 32'(dt[8*w +: 8]));
        chk({tag, ".mst_wr"},     32'(o_swr), 32'(wr[w]));
        chk({tag, ".stops"},      32'(o_stops), 32'd1);
        chk({tag, ".stop_cyc"},   32'(o_stop_cyc), 32'(el - 1));
        chk({tag, ".stop_err"},   32'(o_stop_err), 32'(ee));
        chk({tag, ".rsp_valid"},  32'(o_rv), 32'(eg));
        chk({tag, ".rsp_data"},   32'(o_rd), 32'(ed));
        chk({tag, ".rsp_err"},    32'(o_re), 32'(ee));
        chk({tag, ".latency"},    32'(o_lat), 32'(el));
    endtask

    // Behavioural reference: round-robin winner, watchdog outcome, response rules.
    task automatic run_model(input string tag, input logic [3:0] r, input logic [3:0] wr,
                             input logic [31:0] ad, input logic [31:0] dt, input int d,
                             input logic nk, input logic [7:0] rd);
        int  w   = model_pick(r, ptr_m);
        bit  tmo = (d == 0 || d > TMO);
        int  eff = tmo ? TMO : d;
        logic [7:0] ed = (!tmo && !nk && wr[w]) ? rd : 8'h00;
        run_txn(r, wr, ad, dt, d, nk, rd, 1'b0);
        check_txn(tag, wr, ad, dt, 4'(1 << w), tmo || nk, ed, 4 + eff);
        ptr_m = (w + 1) % NREQ;
    endtask

    initial begin
        logic [31:0] ad_c, dt_c;
        int seen_rv;
        ad_c = {8'h48, 8'h33, 8'h21, DEF_DEV_ADDR};
        dt_c = 32'h4433_2211;
        for (int i = 0; i < 8; i++)
            tbl[i] = '{4'b1111, 4'b0000, ad_c, dt_c, 1, 1'b0, 8'h00, 1'b0,
                       4'(1 << (i % 4)), 1'b0, 8'h00, 5};
        tbl[8]  = '{4'b0001, 4'b0000, ad_c, 32'h4433_22A5, 3, 1'b0, 8'h00, 1'b0, 4'b0001, 1'b0, 8'h00, 7};
        tbl[9]  = '{4'b0100, 4'b0100, ad_c, dt_c, 2, 1'b0, 8'h3C, 1'b0, 4'b0100, 1'b0, 8'h3C, 6};
        tbl[10] = '{4'b1000, 4'b1000, ad_c, dt_c, 0, 1'b0, 8'h77, 1'b0, 4'b1000, 1'b1, 8'h00, 24};
        tbl[11] = '{4'b0001, 4'b0001, ad_c, dt_c, 20, 1'b0, 8'h5A, 1'b0, 4'b0001, 1'b0, 8'h5A, 24};
        tbl[12] = '{4'b0010, 4'b0010, ad_c, dt_c, 21, 1'b0, 8'h66, 1'b0, 4'b0010, 1'b1, 8'h00, 24};
        tbl[13] = '{4'b1100, 4'b0000, ad_c, dt_c, 4, 1'b1, 8'h00, 1'b0, 4'b0100, 1'b1, 8'h00, 8};
        tbl[14] = '{4'b1100, 4'b0000, ad_c, dt_c, 1, 1'b0, 8'h00, 1'b0, 4'b1000, 1'b0, 8'h00, 5};
        tbl[15] = '{4'b0011, 4'b0000, ad_c, dt_c, 2, 1'b0, 8'h00, 1'b1, 4'b0001, 1'b0, 8'h00, 6};
        tbl[16] = '{4'b0010, 4'b0010, ad_c, dt_c, 5, 1'b1, 8'hFF, 1'b0, 4'b0010, 1'b1, 8'h00, 9};

        rst = 1'b0; req = '0; req_wr = '0; req_addr = '0; req_data = '0;
        mst_rdata = '0; mst_done = 1'b0; mst_nack = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.ctl", {11'h0, gnt, rsp_valid, rsp_data, rsp_err, mst_start, mst_stop, mst_wr, busy},
            32'h0000_0002);
        chk("reset.addr_data", {16'h0, mst_addr, mst_data}, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 17; i++) begin
            run_txn(tbl[i].req, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].d,
                    tbl[i].nack, tbl[i].rdata, tbl[i].drop);
            check_txn($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].data,
                      tbl[i].exp_gnt, tbl[i].exp_err, tbl[i].exp_data, tbl[i].exp_lat);
            for (int k = 0; k < NREQ; k++) if (tbl[i].exp_gnt[k]) ptr_m = (k + 1) % NREQ;
        end

        for (int i = 0; i < 40; i++) begin
            run_model($sformatf("rnd%0d", i), 4'($urandom_range(1, 15)), 4'($urandom),
                      $urandom, $urandom, $urandom_range(0, 24),
                      logic'($urandom_range(0, 3) == 0), 8'($urandom));
        end

        // Leave a non-zero pointer and response, then abort a transaction in WAIT.
        run_model("pre_rst", 4'b0010, 4'b0010, ad_c, dt_c, 1, 1'b0, 8'hC3);
        @(negedge clk);
        req = 4'b0100; req_wr = 4'b0100; mst_done = 1'b0;
        seen_rv = 0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            if (rsp_valid != '0) seen_rv++;
        end
        chk("abort.in_wait", {27'h0, busy, gnt}, {27'h0, 1'b1, 4'b0100});
        rst = 1'b0;
        #1;
        chk("abort.ctl", {11'h0, gnt, rsp_valid, rsp_data, rsp_err, mst_start, mst_stop, mst_wr, busy},
            32'h0000_0002);
        chk("abort.addr_data", {16'h0, mst_addr, mst_data}, 32'h0);
        req = '0;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid != '0) seen_rv++;
        end
        chk("abort.no_rsp", 32'(seen_rv), 32'd0);
        rst = 1'b1;
        ptr_m = 0;
        run_model("post_rst", 4'b1110, 4'b0000, ad_c, dt_c, 2, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
Shares one I2C master engine between NREQ requesters. Each requester is a local client such as a sensor poller, a configuration loader or a debug port. The block arbitrates round-robin, latches the winner's command (slave address, direction, write byte) and drives the master's start/stop/command inputs. It then waits for the master to complete or for a watchdog timeout, and returns a response to the winner. It sits between the client logic and i2cmaster and is the only driver of the master's control inputs.

Parameters:
NREQ, 4, number of requesters (2..8)
TIMEOUT, 255, max clk cycles in WAIT before the transaction is aborted (1..65535)
TW, 16, width of the watchdog counter

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  asynchronous, active-low reset
req  input  NREQ  per-requester request level
req_wr  input  NREQ  direction per requester; 0 = write, 1 = read (active-low write, matching the master)
req_addr  input  8*NREQ  slave address, requester i at bits [8i+7:8i]
req_data  input  8*NREQ  write byte, same packing
gnt  output  NREQ  one-hot grant, held for the whole transaction
rsp_valid  output  NREQ  one-cycle one-hot response pulse
rsp_data  output  8  read byte; 0 for writes and errors
rsp_err  output  1  qualifies rsp_valid: 1 = NACK or timeout
mst_start  output  1  one-cycle start pulse to the master
mst_stop  output  1  one-cycle stop pulse to the master
mst_wr  output  1  latched direction
mst_addr  output  8  latched slave address
mst_data  output  8  latched write byte
mst_rdata  input  8  master read data, valid when mst_done=1
mst_done  input  1  one-cycle completion pulse from the master
mst_nack  input  1  slave NACK, sampled with mst_done
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE; rr pointer=0; watchdog=0. All outputs 0 except mst_wr=1 (read, i.e. sda released).
- Reset mid-transaction aborts immediately. No rsp_valid is issued; the requester re-requests after reset.
- States: IDLE -> GRANT -> START -> WAIT -> STOP -> RESP -> IDLE.
- IDLE: if any req bit is set at edge k, pick the first set bit at or after the rr pointer, wrapping modulo NREQ. Next state is GRANT, and gnt is one-hot from cycle k+1.
- GRANT: latch req_wr/req_addr/req_data of the winner into mst_wr/mst_addr/mst_data. Next state is START.
- START: mst_start=1 for exactly one cycle; watchdog cleared. Next state is WAIT.
- WAIT: watchdog increments each cycle.
  - mst_done=1: capture mst_rdata, or 0 if mst_wr=0; rsp_err=mst_nack. Next state is STOP.
  - Watchdog reaches TIMEOUT with no done: rsp_data=0, rsp_err=1. Next state is STOP.
  - mst_done and timeout on the same edge: done wins.
- STOP: mst_stop=1 for exactly one cycle. Next state is RESP.
- RESP: rsp_valid[winner]=1 for one cycle with rsp_data/rsp_err stable. rr pointer = (winner+1) mod NREQ. gnt drops at the exit edge. Next state is IDLE.
- Minimum cycles from req to rsp_valid with mst_done arriving 1 cycle into WAIT: 5.
- Req/grant rules:
  - A requester holds req until rsp_valid.
  - Dropping req after grant is ignored; the transaction completes and rsp_valid still pulses.
  - Re-asserting req in the RESP cycle is allowed and is arbitrated in the following IDLE cycle.
- Non-winner req lines are ignored until IDLE; no queuing beyond the level-held req.
- mst_done outside WAIT is ignored.
- mst_addr/mst_data/mst_wr hold their latched values until the next GRANT.
- rsp_data/rsp_err hold their values after RESP until overwritten.
- Fairness: with all NREQ requesting continuously, each is granted exactly once per NREQ transactions.

Decomposition:
- Shared package i2c_pkg holds:
  - state encoding constants ST_IDLE..ST_RESP, 3 bits
  - WR_WRITE=0 and WR_READ=1
  - default device address 8'b10011101
- One sub-module, i2c_rr_pick (combinational). Inputs: req vector and pointer. Outputs: one-hot grant and binary winner index.
- The FSM, latches and watchdog stay in i2c_bus_arbiter.

Test Plan:
- Reset, then req=4'b0001, req_wr=0, addr0=8'h9D, data0=8'hA5. Master stub pulses done 3 cycles after start with nack=0. Expect:
  - mst_start pulse with mst_addr=8'h9D, mst_data=8'hA5, mst_wr=0
  - one mst_stop pulse
  - rsp_valid=4'b0001, rsp_data=0, rsp_err=0
- req=4'b1111 held for 8 transactions, pointer starting at 0 → grant order 0,1,2,3,0,1,2,3; never two gnt bits set at once.
- Read on requester 2: req_wr=1, stub mst_rdata=8'h3C with done. Expect rsp_valid=4'b0100, rsp_data=8'h3C, rsp_err=0.
- Stub never pulses done, TIMEOUT=20 → rsp_err=1 exactly 20 cycles after the START state, rsp_data=0, mst_stop pulsed once. Repeat with done on the timeout edge → rsp_err=mst_nack, data captured.
- Stub asserts nack=1 with done → rsp_err=1; arbiter returns to IDLE and serves the next requester.
- Assert rst=0 while in WAIT:
  - Expect all outputs 0 asynchronously (mst_wr=1), with no rsp_valid.
  - After release with req=4'b0010, requester 1 is granted with the pointer back at 0.
